// File: rtl/tff_counter.sv
// Up/down modulo-(MAX+1) counter built from a row of falling-edge T flip-flops.
// Terminal values override the ripple toggle vector so the count wraps or saturates at MAX/0.
module tff_cell (
    input  logic clk,
    input  logic clr_n,
    input  logic sclr,
    input  logic load,
    input  logic d,
    input  logic t,
    output logic q
);
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n)    q <= 1'b0;
        else if (sclr) q <= 1'b0;
        else if (load) q <= d;
        else if (t)    q <= ~q;
    end
endmodule

module tff_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX      = 9,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);
    localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];

    logic [WIDTH-1:0] t_up, t_dn, tog, ld_val;
    logic             oor, at_max, at_zero, ovf_nxt;

    // With a full-range MAX nothing can be out of range and no clamp is needed.
    generate
        if (64'(MAX) == ((64'd1 << WIDTH) - 64'd1)) begin : g_full
            assign oor    = 1'b0;
            assign ld_val = din;
        end else begin : g_part
            assign oor    = (q > MAX_V);
            assign ld_val = (din > MAX_V) ? MAX_V : din;
        end
    endgenerate

    assign at_max  = (q == MAX_V);
    assign at_zero = (q == '0);
    assign tc      = up ? at_max : at_zero;

    always_comb begin
        t_up    = '0;
        t_dn    = '0;
        t_up[0] = 1'b1;
        t_dn[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            t_up[i] = t_up[i-1] & q[i-1];
            t_dn[i] = t_dn[i-1] & ~q[i-1];
        end
        tog     = up ? t_up : t_dn;
        ovf_nxt = 1'b0;
        // Toggling q^target lands exactly on target at the range ends.
        if (oor) begin
            tog = q;
        end else if (up && at_max) begin
            tog     = SATURATE ? '0 : q;
            ovf_nxt = 1'b1;
        end else if (!up && at_zero) begin
            tog     = SATURATE ? '0 : MAX_V;
            ovf_nxt = 1'b1;
        end
        if (!en) begin
            tog     = '0;
            ovf_nxt = 1'b0;
        end
    end

    generate
        for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
            tff_cell u_cell (
                .clk   (clk),
                .clr_n (clr_n),
                .sclr  (sclr),
                .load  (load),
                .d     (ld_val[i]),
                .t     (tog[i]),
                .q     (q[i])
            );
        end
    endgenerate

    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n)            ovf <= 1'b0;
        else if (sclr || load) ovf <= 1'b0;
        else                   ovf <= ovf_nxt;
    end
endmodule

// File: tb/tb_tff_counter.sv
// Scoreboard bench for tff_counter: four configurations share one random/directed stimulus
// stream; an arithmetic model predicts q/ovf/tc and a monitor checks them each cycle.
module tb_tff_counter;
    logic       clk = 1'b1;
    logic       clr_n = 1'b0;
    logic       sclr = 1'b0, load = 1'b0, en = 1'b0, up = 1'b1;
    logic [7:0] din = '0;

    logic [3:0] q0, q1, q3;
    logic [7:0] q2;
    logic [3:0] tc_a, ovf_a;
    logic [3:0][7:0] q_a;

    always #5 clk = ~clk;

    tff_counter #(.WIDTH(4), .MAX(9),   .SATURATE(1'b0)) dut_w (.clk(clk), .clr_n(clr_n), .sclr(sclr),
        .load(load), .din(din[3:0]), .en(en), .up(up), .q(q0), .tc(tc_a[0]), .ovf(ovf_a[0]));
    tff_counter #(.WIDTH(4), .MAX(9),   .SATURATE(1'b1)) dut_s (.clk(clk), .clr_n(clr_n), .sclr(sclr),
        .load(load), .din(din[3:0]), .en(en), .up(up), .q(q1), .tc(tc_a[1]), .ovf(ovf_a[1]));
    tff_counter #(.WIDTH(8), .MAX(255), .SATURATE(1'b0)) dut_8 (.clk(clk), .clr_n(clr_n), .sclr(sclr),
        .load(load), .din(din),      .en(en), .up(up), .q(q2), .tc(tc_a[2]), .ovf(ovf_a[2]));
    tff_counter #(.WIDTH(4), .MAX(0),   .SATURATE(1'b0)) dut_z (.clk(clk), .clr_n(clr_n), .sclr(sclr),
        .load(load), .din(din[3:0]), .en(en), .up(up), .q(q3), .tc(tc_a[3]), .ovf(ovf_a[3]));

    assign q_a = {{4'h0, q3}, q2, {4'h0, q1}, {4'h0, q0}};

    localparam int unsigned MAXS [4] = '{9, 9, 255, 0};
    localparam bit          SATS [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    localparam int unsigned MASK [4] = '{15, 15, 255, 15};

    typedef struct packed {
        logic [3:0][7:0] q;
        logic [3:0]      ovf;
        logic [3:0]      tc;
    } exp_t;

    exp_t        sb[$];
    int unsigned mq [4];
    int          passed = 0, total = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req)
            $display("FAIL %s[dut%0d] actual=%0h required=%0h at %0t", name, idx, act, req, $time);
        else
            passed++;
    endtask

    // Reference: the counting rules in plain arithmetic.
    function automatic int unsigned model(input int unsigned q, input int unsigned mx, input bit sat,
                                          input bit s, input bit l, input int unsigned d,
                                          input bit e, input bit u, output bit ov);
        ov = 1'b0;
        if (s) return 0;
        if (l) return (d > mx) ? mx : d;
        if (!e) return q;
        if (q > mx) return 0;
        if (u) begin
            if (q < mx) return q + 1;
            ov = 1'b1;
            return sat ? mx : 0;
        end
        if (q > 0) return q - 1;
        ov = 1'b1;
        return sat ? 0 : mx;
    endfunction

    task automatic step(input bit s, input bit l, input logic [7:0] d, input bit e, input bit u);
        exp_t x;
        bit   ov;
        @(posedge clk);
        #1;
        sclr = s; load = l; din = d; en = e; up = u;
        for (int i = 0; i < 4; i++) begin
            mq[i]    = model(mq[i], MAXS[i], SATS[i], s, l, int'(d) & MASK[i], e, u, ov);
            x.q[i]   = 8'(mq[i]);
            x.ovf[i] = ov;
            x.tc[i]  = u ? (mq[i] == MAXS[i]) : (mq[i] == 0);
        end
        sb.push_back(x);
    endtask

    // Pulse clr_n between edges and check the clear takes effect without a clock.
    task automatic reset_mid();
        exp_t x;
        @(posedge clk);
        #1;
        sclr = 1'b0; load = 1'b0; en = 1'b0;
        clr_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("async_q", i, 32'(q_a[i]), 32'd0);
            chk("async_ovf", i, 32'(ovf_a[i]), 32'd0);
            chk("async_tc", i, 32'(tc_a[i]), up ? 32'(MAXS[i] == 0) : 32'd1);
            mq[i] = 0;
        end
        #1 clr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x.q[i]   = 8'd0;
            x.ovf[i] = 1'b0;
            x.tc[i]  = up ? (MAXS[i] == 0) : 1'b1;
        end
        sb.push_back(x);
    endtask

    // Monitor: outputs settle at the falling edge and are sampled on the rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                for (int i = 0; i < 4; i++) begin
                    chk("q", i, 32'(q_a[i]), 32'(x.q[i]));
                    chk("ovf", i, 32'(ovf_a[i]), 32'(x.ovf[i]));
                    chk("tc", i, 32'(tc_a[i]), 32'(x.tc[i]));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) mq[i] = 0;
        #2;
        for (int i = 0; i < 4; i++) begin
            chk("rst_q", i, 32'(q_a[i]), 32'd0);
            chk("rst_ovf", i, 32'(ovf_a[i]), 32'd0);
            chk("rst_tc", i, 32'(tc_a[i]), 32'(MAXS[i] == 0));
        end
        @(posedge clk);
        #1 clr_n = 1'b1;

        repeat (5) step(0, 0, 8'h00, 1, 1);          // count to 5
        reset_mid();
        repeat (12) step(0, 0, 8'h00, 1, 1);         // decade wrap up
        step(0, 1, 8'h00, 0, 0);
        repeat (3) step(0, 0, 8'h00, 1, 0);          // wrap down
        step(0, 1, 8'h09, 0, 1);
        repeat (3) step(0, 0, 8'h00, 1, 1);          // saturate at MAX
        step(0, 0, 8'h00, 1, 0);
        step(0, 1, 8'h0C, 0, 1);                     // load clamp
        step(0, 1, 8'h03, 1, 1);                     // load beats count
        step(1, 1, 8'h07, 1, 1);                     // sclr beats load
        step(0, 1, 8'hFE, 0, 1);
        repeat (2) step(0, 0, 8'h00, 1, 1);          // 8-bit full-range wrap
        step(0, 0, 8'h00, 0, 1);                     // hold, no ovf

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) reset_mid();
            else step($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                      8'($urandom), $urandom_range(0, 3) != 0, 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) $display("FAIL drain pending=%0d required=0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tff_counter.md
# tff_counter

Parametrised up/down counter built from a row of toggle flip-flops; the multi-bit successor to the single-bit T flip-flop in the counter/flip-flop library. It adds programmable width, a non-power-of-two terminal value, direction control, parallel load, a synchronous clear, an overflow pulse and optional saturation. It is used as the standard modulo-N / decade counting element in timers and dividers.

## Interface

Parameters:
- WIDTH, 4: counter width in bits; legal range 1..32.
- MAX, 9: terminal (highest) count; legal range 0..2**WIDTH-1; the modulus is MAX+1.
- SATURATE, 0: 0 means wrap at the end of the range; 1 means hold at the end of the range.

Ports:
- clk, input, 1: clock; all registers update on the **falling** edge.
- clr_n, input, 1: reset, asynchronous, active-low.
- sclr, input, 1: synchronous clear, active-high.
- load, input, 1: synchronous parallel load.
- din, input, WIDTH: load value.
- en, input, 1: count enable.
- up, input, 1: direction; 1 counts up, 0 counts down.
- q, output, WIDTH: current count (registered).
- tc, output, 1: terminal count (combinational). Equals (q==MAX) when up=1 and (q==0) when up=0.
- ovf, output, 1: registered one-cycle pulse that marks an attempt to step past the end of the range.

## Operation

- Structure: each bit is a T flip-flop.
  - Up: toggle bit i when en=1 and bits 0..i-1 are all 1.
  - Down: toggle bit i when en=1 and bits 0..i-1 are all 0.
  - A terminal override replaces the toggle vector at the range ends. Behaviour must equal the arithmetic description below.
- Priority per falling edge, highest first:
  - clr_n=0 (asynchronous): q=0, ovf=0.
  - sclr=1: q=0, ovf=0.
  - load=1: q = min(din, MAX), ovf=0.
  - en=1, up=1:
    - If q<MAX: q=q+1, ovf=0.
    - If q==MAX: q=0 when SATURATE=0 (MAX when SATURATE=1), ovf=1.
  - en=1, up=0:
    - If q>0: q=q-1, ovf=0.
    - If q==0: q=MAX when SATURATE=0 (0 when SATURATE=1), ovf=1.
  - en=0: q holds, ovf=0.
- Out-of-range state: if q>MAX is ever observed (impossible except via X or fault), the next counting edge forces q=0 and ovf=0.
- Arithmetic is unsigned and modulo MAX+1. It never wraps through 2**WIDTH unless MAX=2**WIDTH-1.
- Direction changes take effect on the same edge; there is no internal direction state.
- MAX=0 case: tc=1 always. Every enabled edge leaves q=0 and pulses ovf.

## Timing

- Reset values: q=0, ovf=0. tc=0 if up=1 (MAX>0), and tc=1 if up=0.
- clr_n assertion clears q and ovf immediately, with no clock required. Deassertion takes effect at the first falling edge after the release.
- Latency: q and ovf change one falling edge after their controls are sampled. tc follows q and up combinationally within the same cycle.
- ovf is high for exactly one clock period per terminal step. With en held high at MAX and SATURATE=1, ovf stays high on every edge (one pulse per attempted step).
- Simultaneous sclr and load: sclr wins. Simultaneous load and en: load wins and no count occurs.
- Reset mid-count discards the count. No ovf is generated by reset.
- Inputs must be stable around the falling edge. The rising edge is unused.

## Test plan

- Async reset: WIDTH=4, MAX=9. Count to 5, pulse clr_n low between edges -> q=0 immediately and ovf=0; tc=0 with up=1.
- Decade wrap up: en=1, up=1 for 12 edges from 0 -> q = 1..9, 0, 1, 2. ovf=1 only in the cycle after 9→0. tc=1 only while q=9.
- Wrap down: up=0 from q=0 -> q=9, 8, 7. ovf pulses once on 0→9. tc=1 at q=0.
- Saturate: SATURATE=1, q=9, up=1, en=1 for 3 edges -> q stays 9 and ovf=1 on each edge. Switch to up=0 -> q=8 and ovf=0.
- Load clamp and priority:
  - load=1, din=4'hC -> q=9.
  - load=1, din=3 with en=1 -> q=3 (no count).
  - sclr=1 with load=1, din=7 -> q=0.
- Generic width: WIDTH=8, MAX=255, up from 254 -> 255 then 0 with ovf=1. MAX=0 -> q stays 0 and ovf=1 on every enabled edge.
